// File: rtl/sensor_avg_filter_if.sv
// Sample-packet bus between a sensor readout block and the averaging filter.
// The producer side drives samples in; the filter side returns filtered packets.
interface sensor_avg_filter_if #(
   parameter int W  = 8,
   parameter int CH = 1
);
   logic            in_valid;
   logic [CH*W-1:0] in_data;
   logic            out_valid;
   logic [CH*W-1:0] out_data;
   logic            out_warm;

   modport master (
      output in_valid, in_data,
      input  out_valid, out_data, out_warm
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, out_data, out_warm
   );
endinterface

// File: rtl/sensor_avg_filter.sv
// Multi-lane moving-average filter: running sum per lane plus a shared circular
// history pointer, shift divide with optional rounding, prime, bypass and flush.
//
// state | meaning
// EMPTY | no samples since reset/clear; next sample may prime the window
// FILL  | window partly filled with real samples, output zero-biased
// FULL  | window holds DEPTH real samples (or was primed), out_warm held high
module sensor_avg_filter #(
   parameter int W          = 8,
   parameter int CH         = 1,
   parameter int LOG2_DEPTH = 2,
   parameter int ROUND      = 0,
   parameter int PRIME      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              bypass,
   sensor_avg_filter_if.slave bus
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW    = W + LOG2_DEPTH;
   localparam logic [SW:0]           HALF     = (ROUND != 0) ? (SW+1)'(DEPTH / 2) : '0;
   localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
   localparam logic [LOG2_DEPTH:0]   CNT_ONE  = (LOG2_DEPTH+1)'(1);
   localparam logic [LOG2_DEPTH:0]   CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);

   typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

   state_t                state;
   logic [LOG2_DEPTH-1:0] wptr;
   logic [LOG2_DEPTH:0]   count;
   logic [SW-1:0]         sum      [CH];
   logic [W-1:0]          hist     [CH][DEPTH];
   logic [SW-1:0]         sum_next [CH];
   logic [SW:0]           rnd      [CH];
   logic [CH*W-1:0]       avg_data;

   // sum never drops below the evicted entry, so the subtraction cannot wrap
   always_comb begin
      avg_data = '0;
      for (int c = 0; c < CH; c++) begin
         sum_next[c] = sum[c] + SW'(bus.in_data[c*W +: W]) - SW'(hist[c][wptr]);
         rnd[c]      = {1'b0, sum_next[c]} + HALF;
         avg_data[c*W +: W] = W'(rnd[c] >> LOG2_DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         wptr          <= '0;
         count         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_warm  <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            sum[c] <= '0;
            for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
         end
      end else if (clear) begin
         state         <= EMPTY;
         wptr          <= '0;
         count         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_warm  <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            sum[c] <= '0;
            for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
         end
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            wptr         <= wptr + PTR_ONE;
            bus.out_data <= bypass ? bus.in_data : avg_data;
            for (int c = 0; c < CH; c++) begin
               sum[c]        <= sum_next[c];
               hist[c][wptr] <= bus.in_data[c*W +: W];
            end
            unique case (state)
               EMPTY: begin
                  if (PRIME != 0) begin
                     // priming replicates the first sample across the whole window
                     for (int c = 0; c < CH; c++) begin
                        sum[c] <= SW'(bus.in_data[c*W +: W]) << LOG2_DEPTH;
                        for (int d = 0; d < DEPTH; d++) hist[c][d] <= bus.in_data[c*W +: W];
                     end
                     bus.out_data <= bus.in_data;
                     bus.out_warm <= 1'b1;
                     count        <= CNT_FULL;
                     state        <= FULL;
                  end else begin
                     count <= CNT_ONE;
                     if (DEPTH == 1) begin
                        bus.out_warm <= 1'b1;
                        state        <= FULL;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
               FILL: begin
                  count <= count + CNT_ONE;
                  if (count + CNT_ONE == CNT_FULL) begin
                     bus.out_warm <= 1'b1;
                     state        <= FULL;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sensor_avg_filter.sv
// Bench for sensor_avg_filter: three configurations (truncate, round, prime) share
// one stimulus stream and are checked against a queue-based window-average model.
module tb_sensor_avg_filter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clear = 1'b0;
   logic bypass = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   sensor_avg_filter_if #(.W(8), .CH(2)) ifa ();
   sensor_avg_filter_if #(.W(8), .CH(2)) ifb ();
   sensor_avg_filter_if #(.W(8), .CH(1)) ifc ();

   sensor_avg_filter #(.W(8), .CH(2), .LOG2_DEPTH(2), .ROUND(0), .PRIME(0)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .bus(ifa));
   sensor_avg_filter #(.W(8), .CH(2), .LOG2_DEPTH(2), .ROUND(1), .PRIME(0)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .bus(ifb));
   sensor_avg_filter #(.W(8), .CH(1), .LOG2_DEPTH(2), .ROUND(0), .PRIME(1)) dut_c (
      .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .bus(ifc));

   logic [15:0] obs_data  [3];
   logic        obs_valid [3];
   logic        obs_warm  [3];
   assign obs_data[0]  = ifa.out_data;
   assign obs_data[1]  = ifb.out_data;
   assign obs_data[2]  = {8'h00, ifc.out_data};
   assign obs_valid[0] = ifa.out_valid;
   assign obs_valid[1] = ifb.out_valid;
   assign obs_valid[2] = ifc.out_valid;
   assign obs_warm[0]  = ifa.out_warm;
   assign obs_warm[1]  = ifb.out_warm;
   assign obs_warm[2]  = ifc.out_warm;

   // Reference model: window = last 4 samples per lane, average by division
   localparam int DEPTH = 4;
   int cfg_round [3] = '{0, 1, 0};
   int cfg_prime [3] = '{0, 0, 1};
   int cfg_lanes [3] = '{2, 2, 1};
   int win   [3][2][$];
   int m_n   [3];
   bit m_warm[3];
   int m_out [3][2];
   bit m_valid;

   function automatic logic [17:0] model_word(input int d);
      return {m_valid, m_warm[d], 8'(m_out[d][1]), 8'(m_out[d][0])};
   endfunction

   task automatic model_flush(input bit also_out);
      for (int d = 0; d < 3; d++) begin
         for (int l = 0; l < 2; l++) begin
            win[d][l] = {0, 0, 0, 0};
            if (also_out) m_out[d][l] = 0;
         end
         m_n[d]    = 0;
         m_warm[d] = 1'b0;
      end
      m_valid = 1'b0;
   endtask

   task automatic model_sample(input int a, input int b, input bit byp);
      int x, s;
      m_valid = 1'b1;
      for (int d = 0; d < 3; d++) begin
         for (int l = 0; l < cfg_lanes[d]; l++) begin
            x = (l == 0) ? a : b;
            if (cfg_prime[d] != 0 && m_n[d] == 0) begin
               win[d][l] = {x, x, x, x};
            end else begin
               win[d][l].push_back(x);
               void'(win[d][l].pop_front());
            end
            s = 0;
            foreach (win[d][l][k]) s += win[d][l][k];
            m_out[d][l] = byp ? x : (s + (cfg_round[d] != 0 ? DEPTH / 2 : 0)) / DEPTH;
         end
         m_n[d]++;
         m_warm[d] = (m_n[d] >= DEPTH) || (cfg_prime[d] != 0);
      end
   endtask

   // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge
   task automatic step(input bit v, input int a, input int b, input bit clr, input bit byp);
      ifa.in_valid = v;
      ifb.in_valid = v;
      ifc.in_valid = v;
      ifa.in_data  = {8'(b), 8'(a)};
      ifb.in_data  = {8'(b), 8'(a)};
      ifc.in_data  = 8'(a);
      clear  = clr;
      bypass = byp;
      @(posedge clk);
      if (rst)      model_flush(1'b1);
      else if (clr) model_flush(1'b0);
      else if (v)   model_sample(a, b, byp);
      else          m_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b1, 33, 44, 1'b0, 1'b0);
      step(1'b1, 55, 66, 1'b0, 1'b0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({obs_valid[d], obs_warm[d], obs_data[d]} !== 18'h0) begin
            fails++;
            $display("FAIL reset dut%0d: got %h want %h", d, {obs_valid[d], obs_warm[d], obs_data[d]}, 18'h0);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 99, 99, 1'b0, 1'b0);
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b0) begin
               fails++;
               $display("FAIL idle_strobe dut%0d cyc%0d: got %b want 0", d, i, obs_valid[d]);
            end
         end
      end
   endtask

   task automatic test_fill();
      int exp_a [4] = '{25, 50, 75, 100};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 100, 7, 1'b0, 1'b0);
         checks++;
         if ({ifa.out_valid, ifa.out_warm, ifa.out_data[7:0]} !== {1'b1, (i == 3), 8'(exp_a[i])}) begin
            fails++;
            $display("FAIL fill_a s%0d: got v%b w%b %0d want v1 w%b %0d",
                     i, ifa.out_valid, ifa.out_warm, ifa.out_data[7:0], (i == 3), exp_a[i]);
         end
         for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_valid[d], obs_warm[d], obs_data[d]} !== model_word(d)) begin
               fails++;
               $display("FAIL fill_model dut%0d s%0d: got %h want %h", d, i, {obs_valid[d], obs_warm[d], obs_data[d]}, model_word(d));
            end
         end
      end
   endtask

   task automatic test_wrap();
      step(1'b1, 20, 7, 1'b0, 1'b0);
      checks++;
      if (ifa.out_data[7:0] !== 8'd80) begin
         fails++;
         $display("FAIL wrap_first got %0d want 80", ifa.out_data[7:0]);
      end
      for (int i = 0; i < 9; i++) begin
         step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
         for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_valid[d], obs_warm[d], obs_data[d]} !== model_word(d)) begin
               fails++;
               $display("FAIL wrap_model dut%0d s%0d: got %h want %h", d, i, {obs_valid[d], obs_warm[d], obs_data[d]}, model_word(d));
            end
         end
      end
      for (int i = 0; i < 4; i++) step(1'b1, 255, 255, 1'b0, 1'b0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs_data[d] !== ((d == 2) ? 16'h00ff : 16'hffff)) begin
            fails++;
            $display("FAIL max_input dut%0d: got %h want all-255", d, obs_data[d]);
         end
      end
   endtask

   task automatic test_round();
      int a_seq [4] = '{1, 2, 2, 2};
      int b_seq [4] = '{200, 0, 50, 9};
      step(1'b0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, a_seq[i], b_seq[i], 1'b0, 1'b0);
         for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_valid[d], obs_warm[d], obs_data[d]} !== model_word(d)) begin
               fails++;
               $display("FAIL round_model dut%0d s%0d: got %h want %h", d, i, {obs_valid[d], obs_warm[d], obs_data[d]}, model_word(d));
            end
         end
      end
      checks++;
      if (ifa.out_data !== {8'd64, 8'd1}) begin
         fails++;
         $display("FAIL round_trunc got %h want %h", ifa.out_data, {8'd64, 8'd1});
      end
      checks++;
      if (ifb.out_data !== {8'd65, 8'd2}) begin
         fails++;
         $display("FAIL round_nearest got %h want %h", ifb.out_data, {8'd65, 8'd2});
      end
   endtask

   task automatic test_clear();
      logic [15:0] held [3];
      for (int i = 0; i < 5; i++) step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0);
      for (int d = 0; d < 3; d++) held[d] = obs_data[d];
      step(1'b1, 250, 250, 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({obs_valid[d], obs_warm[d], obs_data[d]} !== {2'b00, held[d]}) begin
            fails++;
            $display("FAIL clear dut%0d: got %h want %h", d, {obs_valid[d], obs_warm[d], obs_data[d]}, {2'b00, held[d]});
         end
      end
      step(1'b1, 40, 40, 1'b0, 1'b0);
      checks++;
      if ({ifa.out_valid, ifa.out_warm, ifa.out_data} !== {2'b10, 8'd10, 8'd10}) begin
         fails++;
         $display("FAIL after_clear_a got %h want %h", {ifa.out_valid, ifa.out_warm, ifa.out_data}, {2'b10, 8'd10, 8'd10});
      end
      checks++;
      if ({ifc.out_valid, ifc.out_warm, ifc.out_data} !== {2'b11, 8'd40}) begin
         fails++;
         $display("FAIL after_clear_prime got %h want %h", {ifc.out_valid, ifc.out_warm, ifc.out_data}, {2'b11, 8'd40});
      end
   endtask

   task automatic test_prime_bypass();
      int  a_seq [6] = '{60, 80, 90, 200, 10, 50};
      bit  b_seq [6] = '{0, 0, 0, 1, 1, 0};
      step(1'b0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, a_seq[i], 255 - a_seq[i], 1'b0, b_seq[i]);
         if (i == 0) begin
            checks++;
            if ({ifc.out_warm, ifc.out_data} !== {1'b1, 8'd60}) begin
               fails++;
               $display("FAIL prime_first got w%b %0d want w1 60", ifc.out_warm, ifc.out_data);
            end
         end
         if (b_seq[i]) begin
            checks++;
            if (ifa.out_data[7:0] !== 8'(a_seq[i])) begin
               fails++;
               $display("FAIL bypass_raw s%0d got %0d want %0d", i, ifa.out_data[7:0], a_seq[i]);
            end
         end
         for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_valid[d], obs_warm[d], obs_data[d]} !== model_word(d)) begin
               fails++;
               $display("FAIL prime_byp_model dut%0d s%0d: got %h want %h", d, i, {obs_valid[d], obs_warm[d], obs_data[d]}, model_word(d));
            end
         end
      end
      checks++;
      if ({ifa.out_data[7:0], ifc.out_data} !== {8'd87, 8'd87}) begin
         fails++;
         $display("FAIL bypass_exit got %0d/%0d want 87/87", ifa.out_data[7:0], ifc.out_data);
      end
   endtask

   task automatic test_back_to_back();
      bit v, clr, byp;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 29) == 0);
         byp = ($urandom_range(0, 4) == 0);
         step(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), clr, byp);
         for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_valid[d], obs_warm[d], obs_data[d]} !== model_word(d)) begin
               fails++;
               $display("FAIL random dut%0d c%0d: got %h want %h", d, i, {obs_valid[d], obs_warm[d], obs_data[d]}, model_word(d));
            end
         end
      end
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
      ifa.in_data  = '0;   ifb.in_data  = '0;   ifc.in_data  = '0;
      model_flush(1'b1);
      #2;
      test_reset();
      test_fill();
      test_wrap();
      test_round();
      test_clear();
      test_prime_bypass();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
